pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB packed-struct registers into one reusable block. Each stage is carried as a WIDTH-bit payload with a valid/ready handshake on both sides, a 2-entry skid buffer so ready can be registered, and a synchronous flush for branch/jump redirect. Instantiated between every pipeline stage; the payload is the stage struct cast to logic [WIDTH-1:0].

Parameters:
WIDTH, 64, payload width in bits (64 = IF/ID pc+inst; 250 = ID/EX)
BUBBLE_VAL, {WIDTH{1'b0}}, payload value presented as a bubble (used only with the optional feature)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_flush  in  1  synchronous flush; discards all held entries
i_s_vld  in  1  upstream payload valid
o_s_rdy  out  1  upstream ready; registered, no combinational path from i_m_rdy
i_s_data  in  WIDTH  upstream payload
o_m_vld  out  1  downstream payload valid; registered
i_m_rdy  in  1  downstream ready (low = stall from hazard unit)
o_m_data  out  WIDTH  downstream payload; registered (main slot)
o_count  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset (i_reset low, async):
  - state EMPTY; main and skid slots cleared to 0.
  - o_m_vld=0, o_s_rdy=0, o_count=0, o_m_data=0.
  - o_s_rdy rises on the first clock edge after reset release.
- Transfers:
  - Upstream transfer = i_s_vld & o_s_rdy.
  - Downstream transfer = o_m_vld & i_m_rdy.
  - Latency: 1 cycle from upstream transfer to o_m_vld when the block is empty.
  - Throughput: 1 transfer per cycle with i_m_rdy held high.
- States (o_count = 0/1/2):
  - EMPTY: o_s_rdy=1, o_m_vld=0.
    - Upstream transfer -> ONE, main<=i_s_data.
  - ONE: o_s_rdy=1, o_m_vld=1.
    - In & out -> ONE, main<=i_s_data.
    - In & no out -> FULL, skid<=i_s_data.
    - Out & no in -> EMPTY.
    - Neither -> hold.
  - FULL: o_s_rdy=0, o_m_vld=1.
    - Out -> ONE, main<=skid.
    - Otherwise hold.
    - Upstream data is ignored in this state.
- o_s_rdy is the registered value of (next_state != FULL). It never depends on i_m_rdy in the same cycle.
- Flush:
  - Highest priority; next state EMPTY regardless of handshakes.
  - An upstream transfer in the flush cycle is dropped.
  - A downstream transfer in the flush cycle still counts as consumed by the consumer.
  - o_m_vld=0 and o_count=0 from the next cycle.
- Ordering: payloads exit in arrival order; no duplication, no loss except on flush.
- Data slots load only on the transitions listed; otherwise they hold.
- Reset asserted mid-stream clears everything immediately; in-flight payloads are lost.

Optional Feature:
Macro PIPE_STAGE_BUBBLE_EN.
- Defined:
  - On flush, main is loaded with BUBBLE_VAL.
  - On a transition to EMPTY, main is loaded with BUBBLE_VAL.
  - Hence o_m_data == BUBBLE_VAL whenever o_m_vld=0 (e.g. a NOP for an unconditioned consumer).
  - Reset value of main is BUBBLE_VAL.
- Undefined:
  - main holds its last value when empty or flushed.
  - o_m_data is don't-care while o_m_vld=0.

Decomposition:
- Shared package: typedef enum logic [1:0] pipe_buf_state_e {PB_EMPTY, PB_ONE, PB_FULL}.
- Shared package: localparam NOP_INSN = 32'h0000_0013 for RISC-V BUBBLE_VAL construction.
- Shared package: existing stage structs, whose $bits() sets WIDTH.
- Sub-module pipe_buf_slot: WIDTH-bit register with async active-low reset to an init value and a load enable. Instantiated twice (main, skid).

Test Plan:
- Reset, then i_s_vld=1 with data 0x...0001..0x...0004 on consecutive cycles, i_m_rdy=1 -> o_m_vld high from cycle 1 and the same 4 values out in order, one per cycle, o_count=1.
- Send A, B with i_m_rdy=0 -> o_count=2 and o_s_rdy=0 after B. Raise i_m_rdy -> A then B out; o_s_rdy returns to 1 one cycle after A leaves.
- o_count=2, then i_flush=1 with i_s_vld=1 (data C) -> next cycle o_m_vld=0, o_count=0, and C never appears.
- Random i_s_vld/i_m_rdy (50%) over 10k payloads -> scoreboard shows in-order, lossless delivery. Assert no cycle has o_s_rdy depending on the same-cycle i_m_rdy.
- Assert i_reset low while o_count=2 -> outputs 0 immediately (async); after release, o_s_rdy=1 on the first edge.
- PIPE_STAGE_BUBBLE_EN defined, BUBBLE_VAL=0x13 in the inst field -> after flush, o_m_data inst field = 0x00000013 while o_m_vld=0.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the elastic pipeline-stage register: handshake state
// encoding, the RISC-V NOP used to build bubble payloads, and the stage
// structs whose $bits() sets the payload WIDTH of each instance.
package pipe_stage_buf_pkg;

  // Encoding equals the number of entries held, so o_count is the state itself.
  typedef enum logic [1:0] {
    PB_EMPTY = 2'd0,
    PB_ONE   = 2'd1,
    PB_FULL  = 2'd2
  } pipe_buf_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // IF/ID stage payload (64 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // Bubble for the IF/ID register: pc zero, instruction a NOP.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc   = 32'h0;
    b.inst = NOP_INSN;
    return b;
  endfunction

endpackage

// File: rtl/pipe_buf_slot.sv
// One payload slot of the stage buffer: a WIDTH-bit register with a load
// enable and an asynchronous active-low reset to INIT.
module pipe_buf_slot #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Capture i_d when enabled, otherwise hold.
  // NOTE: the slot is a plain register, not a RAM, so giving it an async
  // reset value is cheap and makes the empty/bubble payload well defined.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_q <= INIT;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Payload passes through a registered main slot; a skid slot absorbs the one
// word that may arrive while downstream stalls, so upstream ready is a pure
// register with no combinational path from i_m_rdy.
// Optional build macro PIPE_STAGE_BUBBLE_EN: main is forced to BUBBLE_VAL
// whenever the stage goes empty or is flushed, and resets to BUBBLE_VAL.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_s_vld,
  output logic             o_s_rdy,
  input  logic [WIDTH-1:0] i_s_data,
  output logic             o_m_vld,
  input  logic             i_m_rdy,
  output logic [WIDTH-1:0] o_m_data,
  output logic [1:0]       o_count
);

`ifdef PIPE_STAGE_BUBBLE_EN
  localparam logic [WIDTH-1:0] MAIN_INIT = BUBBLE_VAL;
`else
  localparam logic [WIDTH-1:0] MAIN_INIT = '0;
`endif

  pipe_buf_state_e  state_q, state_d;
  logic             rdy_q, vld_q;
  logic             s_xfer, m_xfer;
  logic             main_load, skid_load, main_from_skid;
  logic             main_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign s_xfer = i_s_vld & rdy_q;
  assign m_xfer = vld_q & i_m_rdy;

  // Next-state and slot-load decode; flush overrides every handshake.
  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      PB_EMPTY: begin
        if (s_xfer) begin
          state_d   = PB_ONE;
          main_load = 1'b1;
        end
      end
      PB_ONE: begin
        case ({s_xfer, m_xfer})
          2'b11:   main_load = 1'b1;
          2'b10: begin
            state_d   = PB_FULL;
            skid_load = 1'b1;
          end
          2'b01:   state_d = PB_EMPTY;
          default: ;
        endcase
      end
      PB_FULL: begin
        if (m_xfer) begin
          state_d        = PB_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = PB_EMPTY;
    endcase
    if (i_flush) begin
      state_d        = PB_EMPTY;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Main-slot input select; in the bubble build, going empty loads BUBBLE_VAL.
  always_comb begin
    main_d  = main_from_skid ? skid_q : i_s_data;
    main_en = main_load;
`ifdef PIPE_STAGE_BUBBLE_EN
    if (i_flush || (state_q != PB_EMPTY && state_d == PB_EMPTY)) begin
      main_d  = BUBBLE_VAL;
      main_en = 1'b1;
    end
`endif
  end

  // State plus registered handshake flags derived from the next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= PB_EMPTY;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != PB_FULL);
      vld_q   <= (state_d != PB_EMPTY);
    end
  end

  pipe_buf_slot #(.WIDTH(WIDTH), .INIT(MAIN_INIT)) u_main (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (main_en),
    .i_d     (main_d),
    .o_q     (main_q)
  );

  pipe_buf_slot #(.WIDTH(WIDTH), .INIT('0)) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (skid_load),
    .i_d     (i_s_data),
    .o_q     (skid_q)
  );

  assign o_s_rdy  = rdy_q;
  assign o_m_vld  = vld_q;
  assign o_m_data = main_q;
  assign o_count  = state_q;

endmodule
